constant_run_detector: RTL and testbench
========================================

// Module: constant_run_detector
// PURPOSE
//  Observes a valid-qualified data stream and decides at runtime whether it is
//  constant. It is the runtime checker for signals the dataflow tests expect to
//  fold to a constant.
//  - Flags a value that repeats on STABLE_CYCLES consecutive valid samples.
//  - Reports whether the stable value equals the expected constant.
//  - Pulses on every value change.
// PARAMETERS
//  WIDTH          8      data width in bits (>=1)
//  STABLE_CYCLES  4      consecutive equal valid samples needed to lock (>=1)
//  EXPECTED       8'h5A  expected constant; WIDTH bits, compared bit-exact
// PORTS
//  clk          in   1                      rising-edge clock
//  rst          in   1                      synchronous, active-high reset
//  flush        in   1                      synchronous clear to IDLE; reset-like, keeps no history
//  in_valid     in   1                      in_data is a sample this cycle
//  in_data      in   WIDTH                  sampled data
//  is_const     out  1                      high while state==LOCKED
//  const_value  out  WIDTH                  last captured sample value
//  matches_exp  out  1                      is_const && const_value==EXPECTED
//  change_pulse out  1                      1-cycle pulse: sample differed from previous one
//  run_count    out  $clog2(STABLE_CYCLES+1) current run length, saturates at STABLE_CYCLES
// BEHAVIOUR
//  - Outputs are all registered. Reset value of every output is 0; state resets to IDLE.
//  - Priority each cycle: rst > flush > in_valid.
//    - flush: state=IDLE, all outputs 0 next cycle. A sample in the same cycle is dropped.
//  - in_valid=0: state, const_value, run_count and is_const hold;
//    change_pulse=0. Gaps never break a run.
//  - FSM, evaluated only when in_valid=1:
//    - IDLE: capture in_data, run_count=1, change_pulse=0 (first sample is not a change).
//      - Go LOCKED if STABLE_CYCLES==1, else TRACK.
//    - TRACK, in_data==const_value: run_count+=1.
//      - Go LOCKED when the new count reaches STABLE_CYCLES.
//    - TRACK, in_data!=const_value: capture in_data, run_count=1, change_pulse=1, stay TRACK.
//    - LOCKED, equal: stay, run_count saturates at STABLE_CYCLES.
//    - LOCKED, differ: capture in_data, run_count=1, change_pulse=1.
//      - Go TRACK, or stay LOCKED if STABLE_CYCLES==1.
//      - is_const falls only on that transition.
//  - Latency: is_const rises the cycle after the STABLE_CYCLES-th equal sample is accepted.
//    It falls the cycle after the first differing sample.
//  - matches_exp: registered alongside is_const from the next-state values;
//    never high while is_const=0.
//  - Equality is full-width and bit-exact. X/Z on in_data while in_valid=1 is illegal;
//    bench asserts against it.
//  - Reset or flush mid-run discards the run; the next valid sample starts from IDLE.
// TESTING
//  1. rst, then in_valid=1 with 8'h5A for 4 cycles (default params)
//     -> run_count 1,2,3,4; is_const=1 and matches_exp=1 after the 4th sample;
//     change_pulse never set.
//  2. Lock on 8'h5A, then one sample 8'h00
//     -> change_pulse=1 for 1 cycle; is_const=0; run_count=1; const_value=8'h00.
//  3. 8'h11 x4 with in_valid low 3 cycles between samples 2 and 3
//     -> lock after the 4th valid sample; is_const=1; matches_exp=0.
//  4. 8'h5A x3, then flush together with a 4th 8'h5A
//     -> next cycle all outputs 0, state IDLE; sample dropped;
//     lock needs 4 new samples.
//  5. STABLE_CYCLES=1: samples 8'h01, 8'h01, 8'h02
//     -> is_const=1 from the first sample; change_pulse only on 8'h02;
//     is_const stays 1; run_count=1 throughout.
//  6. rst asserted while LOCKED with in_valid=1
//     -> all outputs 0 next cycle; rst beats flush and in_valid.

Source files
------------

// File: rtl/constant_run_detector.sv
// Watches a valid-qualified stream and locks once one value repeats on
// STABLE_CYCLES consecutive valid samples; flags changes and expected-constant matches.
module constant_run_detector #(
  parameter int                WIDTH         = 8,
  parameter int                STABLE_CYCLES = 4,
  parameter logic [WIDTH-1:0]  EXPECTED      = WIDTH'(8'h5A),
  localparam int               RW            = $clog2(STABLE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             is_const,
  output logic [WIDTH-1:0] const_value,
  output logic             matches_exp,
  output logic             change_pulse,
  output logic [RW-1:0]    run_count
);

  localparam logic [RW-1:0] SAT     = RW'(STABLE_CYCLES);
  localparam logic [RW-1:0] ONE     = RW'(1);
  localparam bit            LOCK_ON_FIRST = (STABLE_CYCLES == 1);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] value_reg, value_next;
  logic [RW-1:0]    count_reg, count_next;
  logic             pulse_reg, pulse_next;
  logic             const_reg, const_next;
  logic             match_reg, match_next;

  // Per-bit difference between the incoming sample and the captured value.
  logic [WIDTH-1:0] diff_bits;
  logic             same_value;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_diff
      assign diff_bits[gi] = in_data[gi] ^ value_reg[gi];
    end
  endgenerate

  assign same_value = ~|diff_bits;

  always_comb begin
    state_next = state_reg;
    value_next = value_reg;
    count_next = count_reg;
    pulse_next = 1'b0;

    if (flush) begin
      state_next = IDLE;
      value_next = '0;
      count_next = '0;
    end else if (in_valid) begin
      unique case (state_reg)
        IDLE: begin
          value_next = in_data;
          count_next = ONE;
          state_next = LOCK_ON_FIRST ? LOCKED : TRACK;
        end
        TRACK: begin
          if (same_value) begin
            count_next = count_reg + ONE;
            if (count_next == SAT) state_next = LOCKED;
          end else begin
            value_next = in_data;
            count_next = ONE;
            pulse_next = 1'b1;
          end
        end
        LOCKED: begin
          if (same_value) begin
            count_next = SAT;
          end else begin
            value_next = in_data;
            count_next = ONE;
            pulse_next = 1'b1;
            state_next = LOCK_ON_FIRST ? LOCKED : TRACK;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // Flag outputs follow the next state so they line up with the new value.
    const_next = (state_next == LOCKED);
    match_next = const_next && (value_next == EXPECTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      value_reg <= '0;
      count_reg <= '0;
      pulse_reg <= 1'b0;
      const_reg <= 1'b0;
      match_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      value_reg <= value_next;
      count_reg <= count_next;
      pulse_reg <= pulse_next;
      const_reg <= const_next;
      match_reg <= match_next;
    end
  end

  assign is_const     = const_reg;
  assign const_value  = value_reg;
  assign matches_exp  = match_reg;
  assign change_pulse = pulse_reg;
  assign run_count    = count_reg;

endmodule

// File: tb/tb_constant_run_detector.sv
// Bench for constant_run_detector: two instances (STABLE_CYCLES 4 and 1) share
// one stimulus stream and are checked against a run-length reference model.
module tb_constant_run_detector;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid;
  logic [7:0] in_data;

  logic       a_const, a_match, a_pulse;
  logic [7:0] a_val;
  logic [2:0] a_cnt;
  logic       b_const, b_match, b_pulse;
  logic [7:0] b_val;
  logic [0:0] b_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  constant_run_detector #(.WIDTH(8), .STABLE_CYCLES(4), .EXPECTED(8'h5A)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .is_const(a_const), .const_value(a_val), .matches_exp(a_match),
    .change_pulse(a_pulse), .run_count(a_cnt)
  );

  constant_run_detector #(.WIDTH(8), .STABLE_CYCLES(1), .EXPECTED(8'h5A)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .is_const(b_const), .const_value(b_val), .matches_exp(b_match),
    .change_pulse(b_pulse), .run_count(b_cnt)
  );

  always @(posedge clk)
    if (in_valid === 1'b1)
      assert (!$isunknown(in_data)) else $error("in_data unknown while in_valid");

  // Reference: length of the current run of equal samples since the last clear.
  bit       m_have [2];
  logic [7:0] m_last [2];
  int       m_run  [2];
  bit       m_pulse[2];
  int       sc_of  [2] = '{4, 1};

  task automatic model_tick();
    for (int i = 0; i < 2; i++) begin
      m_pulse[i] = 1'b0;
      if (rst || flush) begin
        m_have[i] = 1'b0; m_last[i] = 8'h00; m_run[i] = 0;
      end else if (in_valid) begin
        if (!m_have[i]) begin
          m_have[i] = 1'b1; m_last[i] = in_data; m_run[i] = 1;
        end else if (in_data == m_last[i]) begin
          m_run[i]++;
        end else begin
          m_last[i] = in_data; m_run[i] = 1; m_pulse[i] = 1'b1;
        end
      end
    end
  endtask

  // {is_const, matches_exp, change_pulse, const_value, run_count(3b)}
  function automatic logic [13:0] exp_vec(int i);
    bit locked;
    int cnt;
    locked = m_have[i] && (m_run[i] >= sc_of[i]);
    cnt    = (m_run[i] > sc_of[i]) ? sc_of[i] : m_run[i];
    return {locked, locked && (m_last[i] == 8'h5A), m_pulse[i], m_last[i], 3'(cnt)};
  endfunction

  function automatic logic [13:0] a_vec();
    return {a_const, a_match, a_pulse, a_val, a_cnt};
  endfunction

  function automatic logic [13:0] b_vec();
    return {b_const, b_match, b_pulse, b_val, 2'b00, b_cnt};
  endfunction

  task automatic step(input bit r, input bit f, input bit v, input logic [7:0] d);
    rst = r; flush = f; in_valid = v; in_data = d;
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 8'h00);
    step(1, 1, 1, 8'h5A);
    total++;
    if (a_vec() !== 14'h0) begin
      bad++; $display("FAIL reset_a: got %h expected %h", a_vec(), 14'h0);
    end
    total++;
    if (b_vec() !== 14'h0) begin
      bad++; $display("FAIL reset_b: got %h expected %h", b_vec(), 14'h0);
    end
    step(0, 0, 0, 8'h00);
  endtask

  task automatic test_lock();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 8'h5A);
      total++;
      if (a_cnt !== 3'(i + 1) || a_pulse !== 1'b0) begin
        bad++; $display("FAIL lock_count: got cnt=%0d pulse=%b expected cnt=%0d pulse=0", a_cnt, a_pulse, i + 1);
      end
      total++;
      if (a_const !== (i == 3) || a_match !== (i == 3)) begin
        bad++; $display("FAIL lock_flag: got const=%b match=%b expected %b", a_const, a_match, i == 3);
      end
    end
  endtask

  task automatic test_change();
    step(0, 0, 1, 8'h00);
    total++;
    if (a_vec() !== {1'b0, 1'b0, 1'b1, 8'h00, 3'd1}) begin
      bad++; $display("FAIL change: got %h expected %h", a_vec(), {1'b0, 1'b0, 1'b1, 8'h00, 3'd1});
    end
    step(0, 0, 0, 8'h00);
    total++;
    if (a_pulse !== 1'b0) begin
      bad++; $display("FAIL change_one_cycle: got pulse=%b expected 0", a_pulse);
    end
  endtask

  task automatic test_gaps();
    step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'h11);
    step(0, 0, 1, 8'h11);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'hFF);
    step(0, 0, 1, 8'h11);
    total++;
    if (a_const !== 1'b0 || a_cnt !== 3'd3) begin
      bad++; $display("FAIL gap_hold: got const=%b cnt=%0d expected const=0 cnt=3", a_const, a_cnt);
    end
    step(0, 0, 1, 8'h11);
    total++;
    if (a_const !== 1'b1 || a_match !== 1'b0 || a_val !== 8'h11) begin
      bad++; $display("FAIL gap_lock: got const=%b match=%b val=%h expected 1 0 11", a_const, a_match, a_val);
    end
  endtask

  task automatic test_flush();
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h5A);
    step(0, 1, 1, 8'h5A);
    total++;
    if (a_vec() !== 14'h0) begin
      bad++; $display("FAIL flush_clear: got %h expected %h", a_vec(), 14'h0);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h5A);
    total++;
    if (a_const !== 1'b0 || a_cnt !== 3'd3) begin
      bad++; $display("FAIL flush_relock_early: got const=%b cnt=%0d expected 0 3", a_const, a_cnt);
    end
    step(0, 0, 1, 8'h5A);
    total++;
    if (a_const !== 1'b1 || a_match !== 1'b1) begin
      bad++; $display("FAIL flush_relock: got const=%b match=%b expected 1 1", a_const, a_match);
    end
  endtask

  task automatic test_stable_one();
    logic [7:0] seq [3];
    seq = '{8'h01, 8'h01, 8'h02};
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, seq[i]);
      total++;
      if (b_vec() !== {1'b1, 1'b0, (i == 2), seq[i], 2'b00, 1'b1}) begin
        bad++; $display("FAIL sc1_sample%0d: got %h expected %h", i, b_vec(), {1'b1, 1'b0, (i == 2), seq[i], 2'b00, 1'b1});
      end
    end
  endtask

  task automatic test_rst_locked();
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h5A);
    total++;
    if (a_const !== 1'b1) begin
      bad++; $display("FAIL rst_prelock: got const=%b expected 1", a_const);
    end
    step(1, 1, 1, 8'h5A);
    total++;
    if (a_vec() !== 14'h0 || b_vec() !== 14'h0) begin
      bad++; $display("FAIL rst_locked: got a=%h b=%h expected 0 0", a_vec(), b_vec());
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [4];
    pool = '{8'h5A, 8'h11, 8'h5B, 8'h00};
    for (int n = 0; n < 500; n++) begin
      bit r, f, v;
      logic [7:0] d;
      r = ($urandom_range(0, 99) < 2);
      f = ($urandom_range(0, 99) < 3);
      v = ($urandom_range(0, 99) < 70);
      d = ($urandom_range(0, 9) < 7) ? pool[$urandom_range(0, 1)] : pool[$urandom_range(0, 3)];
      step(r, f, v, d);
      total++;
      if (a_vec() !== exp_vec(0)) begin
        bad++; $display("FAIL rand_a cyc%0d: got %h expected %h", n, a_vec(), exp_vec(0));
      end
      total++;
      if (b_vec() !== exp_vec(1)) begin
        bad++; $display("FAIL rand_b cyc%0d: got %h expected %h", n, b_vec(), exp_vec(1));
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    test_reset();
    test_lock();
    test_change();
    test_gaps();
    test_flush();
    test_stable_one();
    test_rst_locked();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
